// File: rtl/audio_pkg.sv
// Shared types for the audio sample buffer: sample/pair types and playback states.
package audio_pkg;

  localparam int CLK_AUDIO_HZ = 24_576_000;

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PLAY = 2'd1,
    MUTE = 2'd2
  } buf_state_t;

endpackage

// File: rtl/audio_sample_buffer_if.sv
// Sample stream bundle between the I2S receiver side and the audio output side.
interface audio_sample_buffer_if #(
  parameter int AW = 3
);
  import audio_pkg::*;

  sample_t     in_l;
  sample_t     in_r;
  logic        in_valid;
  sample_t     out_l;
  sample_t     out_r;
  logic        out_strobe;
  logic [AW:0] level;
  logic        overflow;
  logic        underrun;
  logic        active;

  modport master (
    output in_l, in_r, in_valid,
    input  out_l, out_r, out_strobe, level, overflow, underrun, active
  );

  modport slave (
    input  in_l, in_r, in_valid,
    output out_l, out_r, out_strobe, level, overflow, underrun, active
  );

endinterface

// File: rtl/audio_pair_fifo.sv
// Circular buffer of stereo pairs with AW+1 bit pointers; a pop and a push in the
// same cycle on a full buffer both succeed because the pop frees the slot first.
module audio_pair_fifo
  import audio_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  stereo_t     push_data,
  input  logic        pop,
  input  logic        flush,
  output stereo_t     pop_data,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;
  stereo_t     mem [2**AW];

  assign level    = wr_ptr - rd_ptr;
  assign full     = level[AW];
  assign empty    = (wr_ptr == rd_ptr);
  assign push_ok  = push && (!full || pop) && !flush;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Flush drops everything queued by pulling the read pointer up to the write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (flush) rd_ptr <= wr_ptr;
      else if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/audio_sample_buffer.sv
// Elastic stereo buffer after the I2S receiver: replays pairs at a fixed CLK_AUDIO
// derived rate, hides underruns by holding the last pair and mutes a silent source.
module audio_sample_buffer
  import audio_pkg::*;
#(
  parameter int AW         = 3,
  parameter int DIV        = 512,
  parameter int MUTE_TICKS = 4800
) (
  input logic                  clk,
  input logic                  reset_n,
  audio_sample_buffer_if.slave bus
);

  localparam int          DW          = $clog2(DIV);
  localparam int          MW          = $clog2(MUTE_TICKS + 1);
  localparam logic [AW:0] START_LEVEL = (AW+1)'(2 ** (AW - 1));

  buf_state_t    state;
  buf_state_t    state_next;
  logic [DW-1:0] div_cnt;
  logic [MW-1:0] mute_cnt;
  logic          tick;
  logic          mute_due;
  logic          pop;
  logic          flush;
  logic          load_out;
  logic          zero_out;
  logic          set_underrun;
  logic [AW:0]   fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  stereo_t       push_data;
  stereo_t       pop_data;

  assign tick      = (div_cnt == DW'(DIV - 1));
  // A pair arriving on the deciding tick keeps the source alive.
  assign mute_due  = tick && !bus.in_valid && (mute_cnt >= MW'(MUTE_TICKS - 1));
  assign push_data = '{l: bus.in_l, r: bus.in_r};
  assign bus.level = fifo_level;

  audio_pair_fifo #(.AW(AW)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (bus.in_valid),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (pop_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    flush        = 1'b0;
    load_out     = 1'b0;
    zero_out     = 1'b0;
    set_underrun = 1'b0;
    case (state)
      FILL: begin
        if (mute_due) begin
          state_next = MUTE;
          flush      = 1'b1;
          zero_out   = 1'b1;
        end else if (tick && (fifo_level >= START_LEVEL)) begin
          state_next = PLAY;
          pop        = 1'b1;
          load_out   = 1'b1;
        end
      end
      PLAY: begin
        if (mute_due) begin
          state_next = MUTE;
          flush      = 1'b1;
          zero_out   = 1'b1;
        end else if (tick) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            load_out = 1'b1;
          end else begin
            set_underrun = 1'b1;
            state_next   = FILL;
          end
        end
      end
      MUTE: begin
        if (tick) zero_out = 1'b1;
        if (bus.in_valid) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FILL;
      div_cnt        <= '0;
      mute_cnt       <= '0;
      bus.out_l      <= '0;
      bus.out_r      <= '0;
      bus.out_strobe <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.underrun   <= 1'b0;
      bus.active     <= 1'b0;
    end else begin
      state          <= state_next;
      div_cnt        <= tick ? '0 : div_cnt + DW'(1);
      bus.out_strobe <= tick;
      bus.active     <= (state_next != MUTE);
      if (bus.in_valid) mute_cnt <= '0;
      else if (tick && (mute_cnt != MW'(MUTE_TICKS))) mute_cnt <= mute_cnt + MW'(1);
      if (load_out) begin
        bus.out_l <= pop_data.l;
        bus.out_r <= pop_data.r;
      end else if (zero_out) begin
        bus.out_l <= '0;
        bus.out_r <= '0;
      end
      if (set_underrun) bus.underrun <= 1'b1;
      if (bus.in_valid && fifo_full && !pop) bus.overflow <= 1'b1;
    end
  end

endmodule
